// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared constants and types for the ALU execute unit.
// Holds ALUOp group codes, funct3 codes, {bit30,funct3} register-group
// codes, the FSM state type, the shift-kind type, the registered output
// payload and a one-bit shift helper used by the iterative shifter.
package alu_exec_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned SHW   = 5;

  // ALUOp groups (decision[3:0])
  localparam logic [3:0] OP_LUI    = 4'h0;
  localparam logic [3:0] OP_AUIPC  = 4'h1;
  localparam logic [3:0] OP_JAL    = 4'h2;
  localparam logic [3:0] OP_JALR   = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_LOAD   = 4'h5;
  localparam logic [3:0] OP_STORE  = 4'h6;
  localparam logic [3:0] OP_IMM    = 4'h7;
  localparam logic [3:0] OP_REG    = 4'h8;
  localparam logic [3:0] OP_FENCE  = 4'h9;
  localparam logic [3:0] OP_SYS    = 4'hA;
  localparam logic [3:0] OP_GRP_B  = 4'hB;
  localparam logic [3:0] OP_GRP_C  = 4'hC;
  localparam logic [3:0] OP_GRP_D  = 4'hD;
  localparam logic [3:0] OP_GRP_E  = 4'hE;
  localparam logic [3:0] OP_GRP_F  = 4'hF;

  // funct3 codes, arithmetic/logic
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 codes, branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // {bit30,funct3} codes for register-register ops
  localparam logic [3:0] GE_ADD  = 4'b0000;
  localparam logic [3:0] GE_SUB  = 4'b1000;
  localparam logic [3:0] GE_SLL  = 4'b0001;
  localparam logic [3:0] GE_SLT  = 4'b0010;
  localparam logic [3:0] GE_SLTU = 4'b0011;
  localparam logic [3:0] GE_XOR  = 4'b0100;
  localparam logic [3:0] GE_SRL  = 4'b0101;
  localparam logic [3:0] GE_SRA  = 4'b1101;
  localparam logic [3:0] GE_OR   = 4'b0110;
  localparam logic [3:0] GE_AND  = 4'b0111;

  typedef enum logic {ST_IDLE, ST_SHIFT} alu_state_e;

  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_kind_e;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          br_taken;
    logic          illegal;
  } alu_out_t;

  // Single-position shift; SRA replicates the sign bit.
  function automatic logic [DW-1:0] shift_one(shift_kind_e k, logic [DW-1:0] v);
    case (k)
      SH_SLL:  shift_one = {v[DW-2:0], 1'b0};
      SH_SRL:  shift_one = {1'b0, v[DW-1:1]};
      default: shift_one = {v[DW-1], v[DW-1:1]};
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// alu_shifter: shift engine for the ALU execute unit.
// Macro ALU_FAST_SHIFT_EN: defined -> combinational barrel shifter (clk,
// rst_n, load, flush unused); undefined -> iterative, one bit per cycle.
// Ports: clk, rst_n, load (capture val/shamt/kind), flush (abandon),
//        kind, val, shamt; res_c (value after the current step / barrel
//        result), last_c (current step is the final one).
module alu_shifter
  import alu_exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  shift_kind_e     kind,
  input  logic [DW-1:0]   val,
  input  logic [SHW-1:0]  shamt,
  output logic [DW-1:0]   res_c,
  output logic            last_c
);

`ifdef ALU_FAST_SHIFT_EN

  logic unused_c;
  assign unused_c = ^{clk, rst_n, load, flush};

  // Single-cycle barrel shift
  always_comb begin
    case (kind)
      SH_SLL:  res_c = val << shamt;
      SH_SRL:  res_c = val >> shamt;
      default: res_c = DW'($signed(val) >>> shamt);
    endcase
  end

  assign last_c = 1'b0;

`else

  logic [DW-1:0]  sreg_q;
  logic [SHW-1:0] cnt_q;
  shift_kind_e    kind_q;

  // Shift register and remaining-step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
    end else if (flush) begin
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= val;
      cnt_q  <= shamt;
      kind_q <= kind;
    end else if (cnt_q != '0) begin
      sreg_q <= shift_one(kind_q, sreg_q);
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  assign res_c  = shift_one(kind_q, sreg_q);
  assign last_c = (cnt_q == SHW'(1));

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32 ALU execute stage with valid/ready on both sides.
// Macro ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter; when
// undefined, shifts by n>=1 take n cycles in state SHIFT.
// Ports: clk, rst_n; in_valid/in_ready, decision {bit30,funct3,ALUOp},
//        op_a, op_b, flush; out_valid/out_ready, result, br_taken,
//        illegal; busy (iterative shift in progress).
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      decision,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic            illegal,
  output logic            busy
);

  alu_state_e  state_q, state_d;
  logic        out_valid_q, valid_d;
  alu_out_t    out_q, out_d;

  logic [3:0]  aluop;
  logic [2:0]  f3;
  logic [3:0]  ge;
  logic        b30;
  logic [DW-1:0] sum_c, diff_c, dec_res, fin_res_c, sh_res_c;
  logic        lt_c, ltu_c, eq_c;
  logic        dec_br, dec_ill, dec_shift, sh_last_c;
  shift_kind_e dec_kind;
  logic        accept_c, start_shift_c;

  assign aluop = decision[3:0];
  assign f3    = decision[6:4];
  assign b30   = decision[7];
  assign ge    = decision[7:4];

  assign sum_c  = op_a + op_b;
  assign diff_c = op_a - op_b;
  assign lt_c   = $signed(op_a) < $signed(op_b);
  assign ltu_c  = op_a < op_b;
  assign eq_c   = op_a == op_b;

  // Decode and compute non-iterative results
  always_comb begin
    dec_res   = '0;
    dec_br    = 1'b0;
    dec_ill   = 1'b0;
    dec_shift = 1'b0;
    dec_kind  = SH_SLL;
    case (aluop)
      OP_LUI: dec_res = op_b;
      OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE: dec_res = sum_c;
      OP_BRANCH: begin
        dec_res = diff_c;
        case (f3)
          F3_BEQ:  dec_br = eq_c;
          F3_BNE:  dec_br = !eq_c;
          F3_BLT:  dec_br = lt_c;
          F3_BGE:  dec_br = !lt_c;
          F3_BLTU: dec_br = ltu_c;
          F3_BGEU: dec_br = !ltu_c;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        case (f3)
          F3_ADD:  dec_res = sum_c;
          F3_SLL:  begin dec_shift = 1'b1; dec_kind = SH_SLL; end
          F3_SLT:  dec_res = DW'(lt_c);
          F3_SLTU: dec_res = DW'(ltu_c);
          F3_XOR:  dec_res = op_a ^ op_b;
          F3_SR:   begin dec_shift = 1'b1; dec_kind = b30 ? SH_SRA : SH_SRL; end
          F3_OR:   dec_res = op_a | op_b;
          default: dec_res = op_a & op_b;
        endcase
      end
      OP_REG: begin
        case (ge)
          GE_ADD:  dec_res = sum_c;
          GE_SUB:  dec_res = diff_c;
          GE_SLL:  begin dec_shift = 1'b1; dec_kind = SH_SLL; end
          GE_SLT:  dec_res = DW'(lt_c);
          GE_SLTU: dec_res = DW'(ltu_c);
          GE_XOR:  dec_res = op_a ^ op_b;
          GE_SRL:  begin dec_shift = 1'b1; dec_kind = SH_SRL; end
          GE_SRA:  begin dec_shift = 1'b1; dec_kind = SH_SRA; end
          GE_OR:   dec_res = op_a | op_b;
          GE_AND:  dec_res = op_a & op_b;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_FENCE, OP_SYS: dec_res = '0;
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept_c = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift_c = 1'b0;
  assign fin_res_c     = dec_shift ? sh_res_c : dec_res;
`else
  // Shift by zero completes immediately with op_a unchanged
  assign start_shift_c = accept_c && dec_shift && (op_b[SHW-1:0] != '0);
  assign fin_res_c     = dec_shift ? op_a : dec_res;
`endif

  alu_shifter u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_shift_c),
    .flush  (flush),
    .kind   (dec_kind),
    .val    (op_a),
    .shamt  (op_b[SHW-1:0]),
    .res_c  (sh_res_c),
    .last_c (sh_last_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= valid_d;
      out_q       <= out_d;
    end
  end

  // Next state, output write and handshake
  always_comb begin
    state_d = state_q;
    valid_d = out_valid_q;
    out_d   = out_q;
    if (out_valid_q && out_ready) valid_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (start_shift_c) begin
              state_d = ST_SHIFT;
            end else begin
              out_d   = '{result: fin_res_c, br_taken: dec_br, illegal: dec_ill};
              valid_d = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_last_c) begin
            out_d   = '{result: sh_res_c, br_taken: 1'b0, illegal: 1'b0};
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = out_q.result;
  assign br_taken  = out_q.br_taken;
  assign illegal   = out_q.illegal;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit. Expected results
// come from a behavioural model and are queued at issue; a negedge
// monitor pops and compares on every output handshake.
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  decision = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready, out_valid, br_taken, illegal, busy;
  logic [31:0] result;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .decision(decision), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .br_taken(br_taken), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [4:0] sh;
    sh = b[4:0];
    e = '0;
    case (d[3:0])
      4'h0: e.res = b;
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6: e.res = a + b;
      4'h4: begin
        e.res = a - b;
        case (d[6:4])
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = ($signed(a) < $signed(b));
          3'd5: e.br = ($signed(a) >= $signed(b));
          3'd6: e.br = (a < b);
          3'd7: e.br = (a >= b);
          default: e.ill = 1'b1;
        endcase
      end
      4'h7: begin
        case (d[6:4])
          3'd0: e.res = a + b;
          3'd1: e.res = a << sh;
          3'd2: e.res = {31'd0, $signed(a) < $signed(b)};
          3'd3: e.res = {31'd0, a < b};
          3'd4: e.res = a ^ b;
          3'd5: e.res = d[7] ? 32'($signed(a) >>> sh) : (a >> sh);
          3'd6: e.res = a | b;
          default: e.res = a & b;
        endcase
      end
      4'h8: begin
        case (d[7:4])
          4'h0: e.res = a + b;
          4'h8: e.res = a - b;
          4'h1: e.res = a << sh;
          4'h2: e.res = {31'd0, $signed(a) < $signed(b)};
          4'h3: e.res = {31'd0, a < b};
          4'h4: e.res = a ^ b;
          4'h5: e.res = a >> sh;
          4'hD: e.res = 32'($signed(a) >>> sh);
          4'h6: e.res = a | b;
          4'h7: e.res = a & b;
          default: e.ill = 1'b1;
        endcase
      end
      4'h9, 4'hA: e.res = '0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Output monitor: compare on each handshake
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexp_out", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("res", result, e.res);
        check("br", 32'(br_taken), 32'(e.br));
        check("ill", 32'(illegal), 32'(e.ill));
      end
    end
  end

  // Random consumer back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n;
    decision = d;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    #2;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(0), 32'(1));
    if (push) sb.push_back(model(d, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n, nb, vcnt;
    logic [7:0]  d;
    logic [31:0] a, b;

    // Reset state
    #3;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_result", result, 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    check("rst_br", 32'(br_taken), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SUB, latency 1
    send(8'h88, 32'd5, 32'd7, 1'b1);
    check("sub_valid", 32'(out_valid), 32'(1));
    check("sub_result", result, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;

    // SRA by 4: latency and busy duration
    send(8'hD8, 32'h8000_0000, 32'd4, 1'b1);
    n = 0;
    nb = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    check("sra_latency", 32'(n), FAST ? 32'(0) : 32'(4));
    check("sra_busy_cycles", 32'(nb), FAST ? 32'(0) : 32'(4));
    check("sra_result", result, 32'hF800_0000);

    // Branch compare signedness
    send(8'h64, 32'd1, 32'hFFFF_FFFF, 1'b1);
    check("bltu_br", 32'(br_taken), 32'(1));
    send(8'h44, 32'd1, 32'hFFFF_FFFF, 1'b1);
    check("blt_br", 32'(br_taken), 32'(0));

    // Illegal encodings
    send(8'hA8, 32'd3, 32'd4, 1'b1);
    check("ill_grpE", 32'(illegal), 32'(1));
    check("ill_grpE_res", result, 32'(0));
    send(8'h0C, 32'd3, 32'd4, 1'b1);
    check("ill_opC", 32'(illegal), 32'(1));
    @(posedge clk);
    #1;

    // Back-pressure hold, then handshake with same-edge acceptance
    out_ready = 1'b0;
    send(8'h08, 32'd8, 32'd8, 1'b1);
    repeat (3) begin
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_result", result, 32'h10);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'(1));
    send(8'h77, 32'h0000_F0F0, 32'h0000_00FF, 1'b1);
    check("bp_next_valid", 32'(out_valid), 32'(1));
    check("bp_next_result", result, 32'h0000_00F0);

    // Random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 7 == 0) a = 32'h8000_0001;
      send(d, a, b, 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;

    // Flush during a long SLL
    send(8'h18, 32'd1, 32'd31, FAST);
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (out_valid) vcnt++;
      @(posedge clk);
      #1;
    end
    check("flush_pre_busy", 32'(busy), FAST ? 32'(0) : 32'(1));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'(0));
    check("flush_valid", 32'(out_valid), 32'(0));
    for (int i = 0; i < 40; i++) begin
      if (out_valid) vcnt++;
      @(posedge clk);
      #1;
    end
    check("flush_no_output", 32'(vcnt), FAST ? 32'(1) : 32'(0));

    // Reset in the middle of a shift
    send(8'h14, 32'd9, 32'd2, 1'b1);
    @(posedge clk);
    #1;
    send(8'h18, 32'd1, 32'd31, FAST);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_result", result, 32'(0));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_valid", 32'(out_valid), 32'(0));
    check("mrst_br", 32'(br_taken), 32'(0));
    #3 rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) vcnt++;
      @(posedge clk);
      #1;
    end
    check("mrst_no_output", 32'(vcnt), 32'(0));
    check("final_queue", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation offered.
REQ-005 in_ready  output  1  operation accepted when in_valid && in_ready at a rising edge.
REQ-006 decision  input  8  {bit30, funct3[2:0], ALUOp[3:0]} from the ALU control stage.
REQ-007 op_a  input  XLEN  rs1 or PC.
REQ-008 op_b  input  XLEN  rs2 or immediate; shift amount = op_b[4:0].
REQ-009 flush  input  1  synchronous abort of in-flight and held results.
REQ-010 out_valid  output  1  result, br_taken and illegal are valid.
REQ-011 out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 result  output  XLEN  computed value.
REQ-013 br_taken  output  1  branch condition outcome (ALUOp 0100 only; else 0).
REQ-014 illegal  output  1  unsupported decision encoding.
REQ-015 busy  output  1  high while in state SHIFT.

Function
REQ-016 FSM states IDLE, SHIFT; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-017 Non-shift ops and shifts with shamt 0: result registered on the acceptance edge; out_valid rises on that edge (latency 1).
REQ-018 Shifts with shamt n>=1: IDLE->SHIFT on acceptance; one bit per cycle; final shift writes output and returns to IDLE; out_valid rises n cycles after acceptance edge.
REQ-019 Output holds stable while out_valid && !out_ready; out_valid clears on handshake unless a new result is written on the same edge.
REQ-020 ALUOp 0000 (LUI): result = op_b; 0001/0010/0011/0101/0110 (AUIPC, JAL, JALR, load, store): result = op_a + op_b mod 2^32.
REQ-021 ALUOp 0100: funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge -> br_taken; result = op_a - op_b; funct3 010/011 -> illegal=1, br_taken=0.
REQ-022 ALUOp 0111: ADDI/SLTI/SLTIU/XORI/ORI/ANDI by funct3, bit30 ignored except funct3 101 (0 SRLI, 1 SRAI); funct3 001 SLLI.
REQ-023 ALUOp 1000: {bit30,funct3} 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; any other combination -> illegal=1, result 0.
REQ-024 SLT/SLTU results are 0 or 1 zero-extended; SRA replicates op_a[31].
REQ-025 ALUOp 1001 (FENCE), 1010: result 0, illegal 0, latency 1; ALUOp 1011-1111: result 0, illegal 1.
REQ-026 flush: next edge forces IDLE, out_valid 0, discards shift in progress; flush and in_valid same cycle -> not accepted.
REQ-027 out_ready ignored while out_valid low; no combinational path from in_valid to out_valid.

Reset
REQ-028 rst_n low: state IDLE, out_valid 0, result 0, br_taken 0, illegal 0, busy 0, shift counter 0, immediately and independent of clk.
REQ-029 Reset mid-SHIFT abandons the operation; no output produced after release.

Configuration
REQ-030 ALU_FAST_SHIFT_EN defined: single-cycle barrel shifter, SHIFT state unused, busy tied 0, all ops latency 1.
REQ-031 ALU_FAST_SHIFT_EN undefined: iterative shifter per REQ-018.

Structure
REQ-032 Package alu_exec_pkg holds ALUOp group constants (LUI..groupF), funct3 constants, {bit30,funct3} groupE codes, FSM state type.
REQ-033 Shifter is sub-module alu_shifter (iterative or barrel per macro); rest in alu_exec_unit.

Verification
REQ-034 decision 0x88 (SUB), op_a 5, op_b 7 -> out_valid next edge, result 0xFFFFFFFE, illegal 0.
REQ-035 decision 0xD8 (SRA), op_a 0x80000000, op_b 4 -> busy 4 cycles, result 0xF8000000; with ALU_FAST_SHIFT_EN, latency 1.
REQ-036 decision 0x64 (BLTU), op_a 1, op_b 0xFFFFFFFF -> br_taken 1; decision 0x44 (BLT) same operands -> br_taken 0.
REQ-037 out_ready held 0 for 3 cycles after ADD result 0x10 -> result stable, in_ready 0; out_ready 1 -> handshake, next op accepted same edge.
REQ-038 SLL shamt 31 in progress, flush at cycle 10 -> IDLE next edge, out_valid never asserted; rst_n low mid-shift -> outputs 0 immediately.
REQ-039 decision 0xA8 ({1,010} groupE) and ALUOp 0xC -> illegal 1, result 0.
